switch_conditioner: RTL
=======================

// Module: switch_conditioner
// PURPOSE
//   Input stage for the DIP switches feeding the jackpot game logic. Synchronises
//   each raw switch to CLOCK, debounces it, and emits clean levels plus one-cycle
//   rise/fall pulses. Downstream logic reads only conditioned switches, never raw pins.
// PARAMETERS
//   WIDTH            4          number of switch bits conditioned in parallel
//   DEBOUNCE_CYCLES  1_250_000  consecutive stable cycles required before accepting a new level (10 ms @ 125 MHz); legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  localparam, per-bit counter width
// PORTS
//   CLOCK           in   1      125 MHz system clock, single clock domain
//   RESET           in   1      synchronous, active-high reset
//   SWITCHES_RAW    in   WIDTH  asynchronous switch pins
//   SWITCHES_CLEAN  out  WIDTH  debounced switch levels
//   SWITCHES_ROSE   out  WIDTH  1-cycle pulse when the CLEAN bit goes 0->1
//   SWITCHES_FELL   out  WIDTH  1-cycle pulse when the CLEAN bit goes 1->0
// BEHAVIOUR
//   - Reset (RESET=1 at a CLOCK edge): sync flops, counters, CLEAN, ROSE and FELL all <= 0.
//     RESET overrides everything, including a counter at terminal count.
//   - Per bit: 2-flop synchroniser, sync1 <= RAW, sync2 <= sync1. No logic between the flops.
//   - Per-bit debounce FSM (state encoded by the CLEAN bit plus counter != 0):
//       STABLE   : sync2 == clean -> cnt <= 0, stay.
//                  sync2 != clean -> cnt <= 1, go to COUNTING.
//       COUNTING : sync2 == clean (bounce) -> cnt <= 0, back to STABLE, no output change.
//                  sync2 != clean, cnt <  N-1 -> cnt <= cnt+1.
//                  sync2 != clean, cnt == N-1 -> clean <= sync2, cnt <= 0, pulse, STABLE.
//   - Latency: a raw change first sampled by sync1 at edge t and held steady appears on
//     CLEAN at edge t+N+1 (N = DEBOUNCE_CYCLES). ROSE/FELL assert in the same cycle CLEAN
//     changes and deassert at the next edge. They are registered, not decoded from CLEAN.
//   - ROSE and FELL are never both high for the same bit. Bits are fully independent, and
//     any combination of bits may pulse in the same cycle.
//   - A glitch shorter than N cycles (as seen at sync2) never reaches CLEAN.
//   - Counter never wraps: it saturates logically at N-1 because the update clears it.
//   - Reset mid-count discards the partial count. A switch held high through reset
//     release produces CLEAN=1 with a ROSE pulse at edge r+N+2 after the last reset
//     edge r (two sync stages refill, then N counting cycles).
// STRUCTURE
//   - Shared package switch_pkg: DEFAULT_DEBOUNCE_CYCLES = 1_250_000,
//     SIM_DEBOUNCE_CYCLES = 4, NUM_SWITCHES = 4.
//   - Sub-module debounce_bit (CLOCK, RESET, RAW, CLEAN, ROSE, FELL; DEBOUNCE_CYCLES
//     parameter) contains the synchroniser, counter and FSM.
//   - switch_conditioner instantiates WIDTH copies of debounce_bit in a generate loop.
//     It contains no other logic.
// TESTING (DEBOUNCE_CYCLES=4, WIDTH=4)
//   1. Assert RESET for 3 cycles with RAW=4'b0000. Expected: CLEAN/ROSE/FELL = 0 and they
//      stay 0 for 20 cycles.
//   2. Set RAW[0] 0->1 and hold it, first sampled at edge t. Expected: CLEAN=4'b0001 at
//      edge t+5, ROSE=4'b0001 for exactly that one cycle, and FELL stays 0.
//   3. With CLEAN[1]=0, make RAW[1] high for 3 cycles and then low. Expected: CLEAN[1]
//      stays 0, with no ROSE/FELL pulse. Then hold RAW[1] high for 6 cycles. Expected:
//      CLEAN[1] rises and pulses exactly once.
//   4. With CLEAN=4'b1111, drop RAW to 4'b0101 at a single edge. Expected: CLEAN=4'b0101
//      on the same edge for both changed bits, FELL=4'b1010 for one cycle, and ROSE=0.
//   5. Hold RAW[2]=1 and assert RESET while the bit is in COUNTING. Expected: CLEAN[2]=0
//      during reset. After release at edge r, expect ROSE[2] at edge r+6, then CLEAN[2]=1.
//   6. Toggle RAW[3] every cycle for 50 cycles, then hold it at 0. Expected: CLEAN[3]
//      stays at its prior value 0 with no pulses. Also check the assertion that ROSE&FELL
//      is 0 on every cycle.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared constants and types for the DIP switch conditioning path.
// Imported by the per-bit debouncer and the top-level wrapper.
package switch_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_250_000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;
    localparam int unsigned NUM_SWITCHES            = 4;

    // Debounce state is not stored; it is derived from the counter being non-zero.
    typedef enum logic {
        StStable   = 1'b0,
        StCounting = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter and debounce FSM
// with registered rise/fall pulses.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic RAW,
    output logic CLEAN,
    output logic ROSE,
    output logic FELL
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rose_q;
    logic             rose_d;
    logic             fell_q;
    logic             fell_d;
    deb_state_e       state;

    // Plain flop chain, nothing between the stages.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= RAW;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rose_q  <= 1'b0;
            fell_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rose_q  <= rose_d;
            fell_q  <= fell_d;
        end
    end

    always_comb begin
        state   = (cnt_q != '0) ? StCounting : StStable;
        cnt_d   = '0;
        clean_d = clean_q;
        rose_d  = 1'b0;
        fell_d  = 1'b0;
        case (state)
            StStable: begin
                if (sync2_q != clean_q) begin
                    cnt_d = CNT_ONE;
                end
            end
            StCounting: begin
                // Any bounce back to the clean level falls through with cnt_d = 0.
                if (sync2_q != clean_q) begin
                    if (cnt_q == CNT_LAST) begin
                        clean_d = sync2_q;
                        rose_d  = sync2_q;
                        fell_d  = ~sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign CLEAN = clean_q;
    assign ROSE  = rose_q;
    assign FELL  = fell_q;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the DIP switch pins for the jackpot logic: WIDTH independent
// synchronise-and-debounce lanes, nothing shared between bits.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH           = NUM_SWITCHES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SWITCHES_RAW,
    output logic [WIDTH-1:0] SWITCHES_CLEAN,
    output logic [WIDTH-1:0] SWITCHES_ROSE,
    output logic [WIDTH-1:0] SWITCHES_FELL
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .CLOCK(CLOCK),
            .RESET(RESET),
            .RAW  (SWITCHES_RAW[i]),
            .CLEAN(SWITCHES_CLEAN[i]),
            .ROSE (SWITCHES_ROSE[i]),
            .FELL (SWITCHES_FELL[i])
        );
    end

endmodule
